// File: rtl/cube_root_pkg.sv
// Shared types and constants for the cube_root block and its multiplier.
// Optional remainder output is enabled with the CUBE_ROOT_REM_EN macro.
package cube_root_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int ITER          = (DEFAULT_WIDTH + 2) / 3;
  localparam int MUL_CYCLES    = 8;
  localparam int SHIFT_W       = $clog2(3 * (ITER - 1) + 1);

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    MUL,
    CMP,
    DONE
  } state_e;

endpackage

// File: rtl/cube_root_if.sv
// Start/busy handshake bundle for cube_root; rem_bo exists only with CUBE_ROOT_REM_EN.
interface cube_root_if
  import cube_root_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start_i;
  logic [WIDTH-1:0] x_bi;
  logic             busy_o;
  logic [WIDTH-1:0] y_bo;
`ifdef CUBE_ROOT_REM_EN
  logic [WIDTH-1:0] rem_bo;

  modport master (output start_i, output x_bi, input busy_o, input y_bo, input rem_bo);
  modport slave  (input start_i, input x_bi, output busy_o, output y_bo, output rem_bo);
`else
  modport master (output start_i, output x_bi, input busy_o, input y_bo);
  modport slave  (input start_i, input x_bi, output busy_o, output y_bo);
`endif

endinterface

// File: rtl/cube_root_mult_shift_add.sv
// Iterative unsigned shift-add multiplier, one operand bit per cycle, truncated product.
// The load edge already consumes the first multiplier bit, so busy spans MUL_CYCLES-1 edges after it.
module mult_shift_add
  import cube_root_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] p_o
);

  localparam int CNT_W = $clog2(MUL_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] aSh_q;
  logic [WIDTH-1:0] bSh_q;
  logic [WIDTH-1:0] prod_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      aSh_q  <= '0;
      bSh_q  <= '0;
      prod_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      aSh_q  <= a_i << 1;
      bSh_q  <= b_i >> 1;
      prod_q <= b_i[0] ? a_i : '0;
      cnt_q  <= CNT_LOAD;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (bSh_q[0]) begin
        prod_q <= prod_q + aSh_q;
      end
      aSh_q <= aSh_q << 1;
      bSh_q <= bSh_q >> 1;
      cnt_q <= cnt_q - CNT_ONE;
      if (cnt_q == CNT_ONE) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign busy_o = busy_q;
  assign p_o    = prod_q;

endmodule

// File: rtl/cube_root.sv
// Sequential floor(cbrt(x)) using restoring 3-bit-group iterations and a shared multiplier.
// Define CUBE_ROOT_REM_EN to also publish the final remainder x - y^3 on rem_bo.
module cube_root
  import cube_root_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic        clk_i,
  input  logic        rst_i,
  cube_root_if.slave  bus
);

  localparam logic [SHIFT_W-1:0] SHIFT_TOP  = SHIFT_W'(3 * (ITER - 1));
  localparam logic [SHIFT_W-1:0] SHIFT_STEP = SHIFT_W'(3);
  localparam logic [WIDTH-1:0]   ONE        = WIDTH'(1);
  localparam logic [WIDTH+3:0]   ONE_W      = (WIDTH + 4)'(1);

  state_e             state_q;
  logic [WIDTH-1:0]   xRem_q;
  logic [WIDTH-1:0]   yAcc_q;
  logic [WIDTH-1:0]   yOut_q;
  logic [SHIFT_W-1:0] shift_q;
  logic               busy_q;
`ifdef CUBE_ROOT_REM_EN
  logic [WIDTH-1:0]   remOut_q;
`endif

  logic [WIDTH-1:0] yShift;
  logic             mulStart;
  logic             mulBusy;
  logic [WIDTH-1:0] mulProd;
  logic [WIDTH+3:0] prodWide;
  logic [WIDTH+3:0] bTerm;
  logic [WIDTH+3:0] xWide;
  logic             fits;

  assign yShift   = yAcc_q << 1;
  assign mulStart = (state_q == PREP);

  mult_shift_add #(
    .WIDTH (WIDTH)
  ) u_mult (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (mulStart),
    .a_i     (yShift),
    .b_i     (yShift + ONE),
    .busy_o  (mulBusy),
    .p_o     (mulProd)
  );

  // Trial subtrahend (3*y*(y+1)+1) << s; extra 4 bits keep the shifted term exact.
  assign prodWide = {4'b0000, mulProd};
  assign bTerm    = ((prodWide << 1) + prodWide + ONE_W) << shift_q;
  assign xWide    = {4'b0000, xRem_q};
  assign fits     = (xWide >= bTerm);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      xRem_q   <= '0;
      yAcc_q   <= '0;
      yOut_q   <= '0;
      shift_q  <= '0;
      busy_q   <= 1'b0;
`ifdef CUBE_ROOT_REM_EN
      remOut_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            xRem_q  <= bus.x_bi;
            yAcc_q  <= '0;
            shift_q <= SHIFT_TOP;
            busy_q  <= 1'b1;
            state_q <= PREP;
          end
        end
        PREP: begin
          yAcc_q  <= yShift;
          state_q <= MUL;
        end
        MUL: begin
          if (!mulBusy) begin
            state_q <= CMP;
          end
        end
        CMP: begin
          if (fits) begin
            xRem_q <= xRem_q - bTerm[WIDTH-1:0];
            yAcc_q <= yAcc_q + ONE;
          end
          if (shift_q == '0) begin
            state_q <= DONE;
          end else begin
            shift_q <= shift_q - SHIFT_STEP;
            state_q <= PREP;
          end
        end
        DONE: begin
          yOut_q   <= yAcc_q;
`ifdef CUBE_ROOT_REM_EN
          remOut_q <= xRem_q;
`endif
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy_o = busy_q;
  assign bus.y_bo   = yOut_q;
`ifdef CUBE_ROOT_REM_EN
  assign bus.rem_bo = remOut_q;
`endif

endmodule

// File: tb/tb_cube_root.sv
// Scoreboard bench for cube_root; checks rem_bo too when CUBE_ROOT_REM_EN is defined.
module tb_cube_root;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] rem;
  } exp_t;

  logic clk = 1'b0;
  logic rstN;
  always #5 clk = ~clk;

  cube_root_if #(.WIDTH(8)) bus ();

  cube_root #(.WIDTH(8)) dut (
    .clk_i (clk),
    .rst_i (rstN),
    .bus   (bus)
  );

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] lastY = 8'd0;

  function automatic exp_t model(input int x);
    exp_t e;
    int   y = 0;
    while ((y + 1) * (y + 1) * (y + 1) <= x) y++;
    e.y   = 8'(y);
    e.rem = 8'(x - y * y * y);
    return e;
  endfunction

  // Pushes the expectation, starts one operation and counts busy cycles until it drops.
  task automatic applyStimulus(input logic [7:0] x, input int hold,
                               output int busyCycles, output bit finished);
    sb.push_back(model(int'(x)));
    busyCycles = 0;
    finished   = 1'b0;
    @(negedge clk);
    bus.x_bi    = x;
    bus.start_i = 1'b1;
    for (int i = 0; i < 100 && !finished; i++) begin
      @(negedge clk);
      if (i == hold - 1) bus.start_i = 1'b0;
      if (bus.busy_o) busyCycles++;
      else finished = 1'b1;
    end
    bus.start_i = 1'b0;
  endtask

  task automatic test_reset;
    rstN        = 1'b0;
    bus.start_i = 1'b0;
    bus.x_bi    = 8'd0;
    #12;
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_busy got=%b want=0", bus.busy_o);
    end
    total++;
    if (bus.y_bo !== 8'd0) begin
      bad++; $display("[TB] FAIL reset_y got=%0d want=0", bus.y_bo);
    end
`ifdef CUBE_ROOT_REM_EN
    total++;
    if (bus.rem_bo !== 8'd0) begin
      bad++; $display("[TB] FAIL reset_rem got=%0d want=0", bus.rem_bo);
    end
`endif
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_ops(input string name, input logic [7:0] xs[$], input int hold);
    int   bc;
    bit   fin;
    exp_t e;
    foreach (xs[k]) begin
      applyStimulus(xs[k], hold, bc, fin);
      e = sb.pop_front();
      total++;
      if (!fin) begin
        bad++; $display("[TB] FAIL %s_timeout x=%0d busy still high after 100 cycles", name, xs[k]);
      end
      total++;
      if (bc !== 31) begin
        bad++; $display("[TB] FAIL %s_latency x=%0d got=%0d want=31", name, xs[k], bc);
      end
      total++;
      if (bus.y_bo !== e.y) begin
        bad++; $display("[TB] FAIL %s_y x=%0d got=%0d want=%0d", name, xs[k], bus.y_bo, e.y);
      end
`ifdef CUBE_ROOT_REM_EN
      total++;
      if (bus.rem_bo !== e.rem) begin
        bad++; $display("[TB] FAIL %s_rem x=%0d got=%0d want=%0d", name, xs[k], bus.rem_bo, e.rem);
      end
`endif
      lastY = e.y;
    end
  endtask

  task automatic test_exact_cubes;
    test_ops("exact", '{8'd0, 8'd1, 8'd8, 8'd27, 8'd64}, 2);
  endtask

  task automatic test_non_cubes;
    test_ops("noncube", '{8'd7, 8'd26, 8'd124, 8'd215, 8'd63, 8'd125, 8'd216}, 1);
  endtask

  task automatic test_max;
    test_ops("max", '{8'd255}, 1);
  endtask

  task automatic test_ignore_busy;
    int   bc  = 0;
    bit   fin = 1'b0;
    exp_t e;
    sb.push_back(model(125));
    @(negedge clk);
    bus.x_bi    = 8'd125;
    bus.start_i = 1'b1;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(negedge clk);
      if (i == 0) bus.start_i = 1'b0;
      if (i == 4) begin
        bus.x_bi    = 8'd8;
        bus.start_i = 1'b1;
      end
      if (i == 6) bus.start_i = 1'b0;
      if (i == 10) begin
        total++;
        if (bus.y_bo !== lastY) begin
          bad++; $display("[TB] FAIL hold_prev_y got=%0d want=%0d", bus.y_bo, lastY);
        end
      end
      if (bus.busy_o) bc++;
      else fin = 1'b1;
    end
    e = sb.pop_front();
    total++;
    if (bc !== 31) begin
      bad++; $display("[TB] FAIL ignore_latency got=%0d want=31", bc);
    end
    total++;
    if (bus.y_bo !== e.y) begin
      bad++; $display("[TB] FAIL ignore_y got=%0d want=%0d", bus.y_bo, e.y);
    end
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++; $display("[TB] FAIL ignore_no_restart got=%b want=0", bus.busy_o);
    end
    lastY = e.y;
  endtask

  task automatic test_reset_mid;
    int bc;
    bit fin;
    @(negedge clk);
    bus.x_bi    = 8'd216;
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (11) @(negedge clk);
    #2 rstN = 1'b0;
    #1;
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++; $display("[TB] FAIL abort_busy got=%b want=0", bus.busy_o);
    end
    total++;
    if (bus.y_bo !== 8'd0) begin
      bad++; $display("[TB] FAIL abort_y got=%0d want=0", bus.y_bo);
    end
    @(negedge clk);
    rstN  = 1'b1;
    lastY = 8'd0;
    applyStimulus(8'd216, 1, bc, fin);
    begin
      exp_t e;
      e = sb.pop_front();
      total++;
      if (!fin || bc !== 31) begin
        bad++; $display("[TB] FAIL after_abort_latency got=%0d want=31 finished=%0d", bc, fin);
      end
      total++;
      if (bus.y_bo !== e.y) begin
        bad++; $display("[TB] FAIL after_abort_y got=%0d want=%0d", bus.y_bo, e.y);
      end
      lastY = e.y;
    end
  endtask

  task automatic test_back_to_back;
    int   bc;
    bit   fin;
    exp_t e;
    for (int op = 0; op < 3; op++) sb.push_back(model(27));
    @(negedge clk);
    bus.x_bi    = 8'd27;
    bus.start_i = 1'b1;
    for (int op = 0; op < 3; op++) begin
      bc  = 0;
      fin = 1'b0;
      for (int i = 0; i < 100 && !fin; i++) begin
        @(negedge clk);
        if (bus.busy_o) bc++;
        else fin = 1'b1;
      end
      if (op == 2) bus.start_i = 1'b0;
      e = sb.pop_front();
      total++;
      if (bc !== 31) begin
        bad++; $display("[TB] FAIL b2b_latency op=%0d got=%0d want=31", op, bc);
      end
      total++;
      if (bus.y_bo !== e.y) begin
        bad++; $display("[TB] FAIL b2b_y op=%0d got=%0d want=%0d", op, bus.y_bo, e.y);
      end
    end
    @(negedge clk);
    total++;
    if (bus.busy_o !== 1'b0) begin
      bad++; $display("[TB] FAIL b2b_stop got=%b want=0", bus.busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_exact_cubes();
    test_non_cubes();
    test_max();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    total++;
    if (sb.size() !== 0) begin
      bad++; $display("[TB] FAIL scoreboard_left got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
